pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter N, default 32, data-field width (alu result and store data).
REQ-002 SHALL have parameter RW, default 5, destination-register address width.
REQ-003 SHALL have parameter CW, default 3, control-field width; bit 0 = wr_en, bit 1 = wd_sel, bit 2 = wm_en.
REQ-004 SHALL have parameter SW, default 16, stall-counter width.
REQ-005 SHALL have port clock  input  1  single clock; all state changes on the rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port flush  input  1  synchronous squash of all held entries.
REQ-008 SHALL have port in_valid  input  1  upstream entry present.
REQ-009 SHALL have port in_ready  output  1  stage can accept the upstream entry this cycle.
REQ-010 SHALL have port ctrl_in  input  CW  upstream control bits.
REQ-011 SHALL have port rw_in  input  RW  upstream destination register.
REQ-012 SHALL have port alu_in  input  N  upstream ALU result.
REQ-013 SHALL have port rdb_in  input  N  upstream store data.
REQ-014 SHALL have port out_valid  output  1  head entry present.
REQ-015 SHALL have port out_ready  input  1  downstream accepts the head entry.
REQ-016 SHALL have ports ctrl_out (CW), rw_out (RW), alu_out (N), rdb_out (N)  output  head entry fields.
REQ-017 SHALL have port occupancy  output  2  number of held entries, 0..2.
REQ-018 SHALL have port stall_cnt  output  SW  count of back-pressured cycles.

Function
REQ-019 SHALL define in-fire as in_valid && in_ready and out-fire as out_valid && out_ready.
REQ-020 SHALL hold entries in a main register, which drives the outputs, and a skid register; the FSM states are EMPTY, ONE and TWO.
REQ-021 SHALL drive in_ready = (state != TWO) && !flush.
REQ-022 SHALL drive out_valid = (state != EMPTY), and occupancy = 0, 1 or 2 for EMPTY, ONE or TWO.
REQ-023 SHALL force ctrl_out to 0 whenever out_valid = 0, so a bubble never writes a register or memory.
REQ-024 SHALL, in EMPTY on in-fire, load main from the inputs and move to ONE.
REQ-025 SHALL, in ONE on in-fire with out-fire, load main from the inputs and stay in ONE.
REQ-026 SHALL, in ONE on in-fire without out-fire, load skid from the inputs and move to TWO.
REQ-027 SHALL, in ONE on out-fire without in-fire, move to EMPTY.
REQ-028 SHALL, in TWO on out-fire, copy skid into main and move to ONE; no input is accepted in TWO.
REQ-029 SHALL hold state and all registers when none of REQ-024..028 applies.
REQ-030 SHALL give latency of exactly 1 cycle from in-fire into EMPTY to out_valid = 1, with the entry's fields unchanged.
REQ-031 SHALL sustain one entry per cycle while out_ready = 1.
REQ-032 SHALL deliver entries in arrival order with no loss or duplication under any out_ready pattern.
REQ-033 SHALL give flush priority over every other event: next state EMPTY, main and skid control fields cleared, and any out-fire in the flush cycle still counted as delivered.
REQ-034 SHALL increment stall_cnt on every cycle with out_valid && !out_ready, saturating at all-ones (no wrap).
REQ-035 SHALL clear stall_cnt only by reset; flush does not clear it.

Reset
REQ-036 SHALL, while reset = 0, immediately force state EMPTY, all main and skid fields to 0, stall_cnt to 0, out_valid = 0 and occupancy = 0.
REQ-037 SHALL discard held entries when reset is asserted mid-operation, with no partial output.
REQ-038 SHALL accept input on the first rising edge after reset deasserts if in_valid = 1 and flush = 0.

Verification
REQ-039 Bench SHALL cover: reset, then in_valid = 1 with ctrl_in = 3'b001, rw_in = 5, alu_in = 0x1234 for 1 cycle, out_ready = 1 -> next cycle out_valid = 1, rw_out = 5, alu_out = 0x1234; following cycle out_valid = 0 and ctrl_out = 0.
REQ-040 Bench SHALL cover: out_ready = 0 while entries A = 0x11 and B = 0x22 are pushed on back-to-back cycles -> occupancy = 2, in_ready = 0; after out_ready = 1, outputs A then B on consecutive cycles.
REQ-041 Bench SHALL cover: continuous stream 0..99 with out_ready = 1 -> 100 outputs in order, one per cycle, with in_ready held at 1.
REQ-042 Bench SHALL cover: random in_valid/out_ready over 10000 cycles -> scoreboard shows order preserved and no loss; stall_cnt equals the counted back-pressured cycles.
REQ-043 Bench SHALL cover: occupancy = 2, then flush = 1 for 1 cycle with in_valid = 1 -> in_ready = 0 that cycle; next cycle occupancy = 0, out_valid = 0, ctrl_out = 0, and the input is not captured.
REQ-044 Bench SHALL cover: SW = 4 with out_ready held at 0 for 20 cycles at occupancy = 1 -> stall_cnt = 15; asynchronous reset pulse mid-cycle -> outputs 0 before the next clock edge.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// Two-entry pipeline register with skid buffer between execute and memory stages.
// Accepts one entry per cycle under a steady out_ready and absorbs one extra entry when downstream stalls.
module pipe_skid_stage #(
    parameter int N  = 32,
    parameter int RW = 5,
    parameter int CW = 3,
    parameter int SW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] ctrl_in,
    input  logic [RW-1:0] rw_in,
    input  logic [N-1:0]  alu_in,
    input  logic [N-1:0]  rdb_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] ctrl_out,
    output logic [RW-1:0] rw_out,
    output logic [N-1:0]  alu_out,
    output logic [N-1:0]  rdb_out,
    output logic [1:0]    occupancy,
    output logic [SW-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;

    logic [CW-1:0] main_ctrl;
    logic [RW-1:0] main_rw;
    logic [N-1:0]  main_alu;
    logic [N-1:0]  main_rdb;

    logic [CW-1:0] skid_ctrl;
    logic [RW-1:0] skid_rw;
    logic [N-1:0]  skid_alu;
    logic [N-1:0]  skid_rdb;

    logic          in_fire;
    logic          out_fire;
    logic          load_main_in;
    logic          load_main_skid;
    logic          load_skid_in;

    assign in_ready  = (state != TWO) && !flush;
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // A bubble must never carry write enables downstream.
    assign ctrl_out = out_valid ? main_ctrl : '0;
    assign rw_out   = main_rw;
    assign alu_out  = main_alu;
    assign rdb_out  = main_rdb;

    always_comb begin
        occupancy = 2'd0;
        case (state)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        load_main_in = 1'b1;
                        next_state   = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        load_skid_in = 1'b1;
                        next_state   = TWO;
                    end else if (out_fire) begin
                        next_state = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        load_main_skid = 1'b1;
                        next_state     = ONE;
                    end
                end
                default: next_state = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: the data registers are reset too, so no stale field can appear after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            main_ctrl <= '0;
            main_rw   <= '0;
            main_alu  <= '0;
            main_rdb  <= '0;
        end else if (flush) begin
            main_ctrl <= '0;
        end else if (load_main_in) begin
            main_ctrl <= ctrl_in;
            main_rw   <= rw_in;
            main_alu  <= alu_in;
            main_rdb  <= rdb_in;
        end else if (load_main_skid) begin
            main_ctrl <= skid_ctrl;
            main_rw   <= skid_rw;
            main_alu  <= skid_alu;
            main_rdb  <= skid_rdb;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            skid_ctrl <= '0;
            skid_rw   <= '0;
            skid_alu  <= '0;
            skid_rdb  <= '0;
        end else if (flush) begin
            skid_ctrl <= '0;
        end else if (load_skid_in) begin
            skid_ctrl <= ctrl_in;
            skid_rw   <= rw_in;
            skid_alu  <= alu_in;
            skid_rdb  <= rdb_in;
        end
    end

    // Saturating back-pressure counter; survives flush so stall statistics span squashes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + SW'(1);
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios plus a long random run
// compared against a queue-based reference model.
module tb_pipe_skid_stage;

    localparam int N  = 32;
    localparam int RW = 5;
    localparam int CW = 3;
    localparam int SW = 16;
    localparam int EW = CW + RW + N + N;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] ctrl_in = '0;
    logic [RW-1:0] rw_in = '0;
    logic [N-1:0]  alu_in = '0;
    logic [N-1:0]  rdb_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] ctrl_out;
    logic [RW-1:0] rw_out;
    logic [N-1:0]  alu_out;
    logic [N-1:0]  rdb_out;
    logic [1:0]    occupancy;
    logic [SW-1:0] stall_cnt;

    // Second instance with a narrow stall counter for the saturation scenario.
    logic          rst4 = 1'b0;
    logic          iv4 = 1'b0;
    logic          rdy4;
    logic [CW-1:0] ctrl_in4 = '0;
    logic [RW-1:0] rw_in4 = '0;
    logic [N-1:0]  alu_in4 = '0;
    logic [N-1:0]  rdb_in4 = '0;
    logic          ov4;
    logic          or4 = 1'b0;
    logic [CW-1:0] ctrl_out4;
    logic [RW-1:0] rw_out4;
    logic [N-1:0]  alu_out4;
    logic [N-1:0]  rdb_out4;
    logic [1:0]    occ4;
    logic [3:0]    stall4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [EW-1:0] q[$];
    int            model_stall = 0;

    always #5 clock = ~clock;

    pipe_skid_stage #(.N(N), .RW(RW), .CW(CW), .SW(SW)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ctrl_in(ctrl_in), .rw_in(rw_in), .alu_in(alu_in), .rdb_in(rdb_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .ctrl_out(ctrl_out), .rw_out(rw_out), .alu_out(alu_out), .rdb_out(rdb_out),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_skid_stage #(.N(N), .RW(RW), .CW(CW), .SW(4)) dut4 (
        .clock(clock), .reset(rst4), .flush(1'b0),
        .in_valid(iv4), .in_ready(rdy4),
        .ctrl_in(ctrl_in4), .rw_in(rw_in4), .alu_in(alu_in4), .rdb_in(rdb_in4),
        .out_valid(ov4), .out_ready(or4),
        .ctrl_out(ctrl_out4), .rw_out(rw_out4), .alu_out(alu_out4), .rdb_out(rdb_out4),
        .occupancy(occ4), .stall_cnt(stall4)
    );

    function automatic logic [EW-1:0] mk(input logic [CW-1:0] c, input logic [RW-1:0] r,
                                         input logic [N-1:0] a, input logic [N-1:0] b);
        return {c, r, a, b};
    endfunction

    // One clock cycle: drive inputs, compare against the queue model, advance both.
    task automatic cycle(input logic iv, input logic [EW-1:0] e, input logic ordy, input logic fl);
        logic          exp_rdy;
        logic          exp_v;
        logic [1:0]    exp_occ;
        logic [EW-1:0] exp_head;
        logic [EW-1:0] obs_head;
        logic          in_f;
        logic          out_f;
        {ctrl_in, rw_in, alu_in, rdb_in} = e;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_v    = (q.size() != 0);
        exp_occ  = 2'(q.size());
        exp_rdy  = (q.size() < 2) && !fl;
        exp_head = exp_v ? q[0] : '0;
        obs_head = out_valid ? {ctrl_out, rw_out, alu_out, rdb_out}
                             : {ctrl_out, {(RW + N + N){1'b0}}};
        checks++;
        if ({out_valid, occupancy, in_ready} !== {exp_v, exp_occ, exp_rdy}) begin
            errors++;
            $display("FAIL handshake cyc %0d: got v=%b occ=%0d rdy=%b, expected v=%b occ=%0d rdy=%b",
                     cyc, out_valid, occupancy, in_ready, exp_v, exp_occ, exp_rdy);
        end
        checks++;
        if (obs_head !== exp_head) begin
            errors++;
            $display("FAIL head cyc %0d: got %h, expected %h", cyc, obs_head, exp_head);
        end
        checks++;
        if (stall_cnt !== SW'(model_stall)) begin
            errors++;
            $display("FAIL stall_cnt cyc %0d: got %0d, expected %0d", cyc, stall_cnt, model_stall);
        end
        in_f  = iv && exp_rdy;
        out_f = exp_v && ordy;
        if (exp_v && !ordy && model_stall < (1 << SW) - 1) model_stall++;
        @(posedge clock);
        #1;
        cyc++;
        if (fl) begin
            q.delete();
        end else begin
            if (out_f) void'(q.pop_front());
            if (in_f) q.push_back(e);
        end
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, ordy, 1'b0);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({out_valid, occupancy, ctrl_out, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b occ=%0d ctrl=%b stall=%0d, expected all 0",
                     out_valid, occupancy, ctrl_out, stall_cnt);
        end
        checks++;
        if ({rw_out, alu_out, rdb_out} !== '0) begin
            errors++;
            $display("FAIL reset_fields: got rw=%0d alu=%h rdb=%h, expected 0", rw_out, alu_out, rdb_out);
        end
        #20;
        reset = 1'b1;
        rst4  = 1'b1;
        q.delete();
        model_stall = 0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_single();
        cycle(1'b1, mk(3'b001, 5'd5, 32'h1234, 32'h0), 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || rw_out !== 5'd5 || alu_out !== 32'h1234 || ctrl_out !== 3'b001) begin
            errors++;
            $display("FAIL single_out: got v=%b rw=%0d alu=%h ctrl=%b, expected v=1 rw=5 alu=1234 ctrl=001",
                     out_valid, rw_out, alu_out, ctrl_out);
        end
        idle(1'b1);
        checks++;
        if (out_valid !== 1'b0 || ctrl_out !== 3'b000) begin
            errors++;
            $display("FAIL single_bubble: got v=%b ctrl=%b, expected v=0 ctrl=000", out_valid, ctrl_out);
        end
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, mk(3'b111, 5'd1, 32'h11, 32'hA), 1'b0, 1'b0);
        cycle(1'b1, mk(3'b011, 5'd2, 32'h22, 32'hB), 1'b0, 1'b0);
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || alu_out !== 32'h11) begin
            errors++;
            $display("FAIL b2b_full: got occ=%0d rdy=%b alu=%h, expected occ=2 rdy=0 alu=11",
                     occupancy, in_ready, alu_out);
        end
        idle(1'b1);
        checks++;
        if (occupancy !== 2'd1 || out_valid !== 1'b1 || alu_out !== 32'h22) begin
            errors++;
            $display("FAIL b2b_second: got occ=%0d v=%b alu=%h, expected occ=1 v=1 alu=22",
                     occupancy, out_valid, alu_out);
        end
        idle(1'b1);
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got occ=%0d v=%b, expected occ=0 v=0", occupancy, out_valid);
        end
    endtask

    task automatic test_stream();
        int bad = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, mk(3'b001, RW'(i), N'(i), N'(i * 3)), 1'b1, 1'b0);
            if (out_valid !== 1'b1 || alu_out !== N'(i) || in_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stream: got %0d of 100 cycles off, expected 0", bad);
        end
        idle(1'b1);
    endtask

    task automatic test_flush();
        cycle(1'b1, mk(3'b101, 5'd7, 32'h77, 32'h1), 1'b0, 1'b0);
        cycle(1'b1, mk(3'b110, 5'd8, 32'h88, 32'h2), 1'b0, 1'b0);
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got occ=%0d rdy=%b, expected occ=2 rdy=0", occupancy, in_ready);
        end
        cycle(1'b1, mk(3'b111, 5'd9, 32'h99, 32'h3), 1'b0, 1'b1);
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || ctrl_out !== '0) begin
            errors++;
            $display("FAIL flush_empty: got occ=%0d v=%b ctrl=%b, expected 0 0 000", occupancy, out_valid, ctrl_out);
        end
        idle(1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_capture: got v=%b, expected v=0", out_valid);
        end
    endtask

    task automatic test_random();
        int pushes = 0;
        for (int i = 0; i < 10000; i++) begin
            logic iv;
            logic ordy;
            logic fl;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 39) == 0);
            if (iv && q.size() < 2 && !fl) pushes++;
            cycle(iv, mk(CW'($urandom), RW'($urandom), $urandom, $urandom), ordy, fl);
        end
        idle(1'b1);
        idle(1'b1);
        checks++;
        if (stall_cnt !== SW'(model_stall) || out_valid !== 1'b0 || pushes == 0) begin
            errors++;
            $display("FAIL random_final: got stall=%0d v=%b pushes=%0d, expected stall=%0d v=0 pushes>0",
                     stall_cnt, out_valid, pushes, model_stall);
        end
    endtask

    task automatic test_stall_sat();
        {ctrl_in4, rw_in4, alu_in4, rdb_in4} = mk(3'b011, 5'd3, 32'hCAFE, 32'hBEEF);
        iv4 = 1'b1;
        or4 = 1'b0;
        @(posedge clock);
        #1;
        iv4 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
        end
        #1;
        checks++;
        if (occ4 !== 2'd1 || stall4 !== 4'd10) begin
            errors++;
            $display("FAIL stall_mid: got occ=%0d stall=%0d, expected occ=1 stall=10", occ4, stall4);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
        end
        #1;
        checks++;
        if (stall4 !== 4'd15) begin
            errors++;
            $display("FAIL stall_sat: got %0d, expected 15", stall4);
        end
        #1;
        rst4 = 1'b0;
        #1;
        checks++;
        if ({ov4, occ4, ctrl_out4, stall4, rw_out4, alu_out4, rdb_out4} !== '0) begin
            errors++;
            $display("FAIL async_reset: got v=%b occ=%0d ctrl=%b stall=%0d alu=%h, expected all 0",
                     ov4, occ4, ctrl_out4, stall4, alu_out4);
        end
        #4;
        rst4 = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stream();
        test_flush();
        test_random();
        test_stall_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
